nina_decoder_d1_k1: RTL and testbench

Output-side decoder for the first-order, single-fault (d=1, k=1) NINA-protected datapath. It accepts one masked, triplicated bit per beat (2 shares x 3 copies) and majority-corrects each share. It recombines the shares into the unmasked bit, flags copy disagreement, and keeps a saturating fault counter. The counter escalates to a sticky alarm that blocks the datapath until software clears it. The block sits at the boundary where a protected gadget chain hands results to unprotected logic.

---
 rtl/nina_pkg.sv | 24 ++
 rtl/nina_maj3.sv | 16 +
 rtl/nina_decoder_d1_k1.sv | 133 +++++++++++++
 tb/tb_nina_decoder_d1_k1.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nina_pkg.sv
`default_nettype none
// ============================================================================
// nina_pkg : shared types and constants for the d=1,k=1 NINA datapath
// Rev 1.0  : initial release
// ============================================================================
package nina_pkg;

    localparam int NINA_SHARES = 2;
    localparam int NINA_COPIES = 3;

    typedef logic [NINA_COPIES-1:0] share_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        ALARM = 1'b1
    } state_t;

    // A share is fault-free only when all of its copies agree.
    function automatic logic is_consistent(input share_t s);
        return (s == '0) || (s == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nina_maj3.sv
`default_nettype none
// ============================================================================
// nina_maj3 : 3-input majority voter, one instance per share
// Rev 1.0   : initial release
// ============================================================================
module nina_maj3
    import nina_pkg::*;
(
    input  share_t x_i,
    output logic   y_o
);

    assign y_o = (x_i[0] & x_i[1]) | (x_i[0] & x_i[2]) | (x_i[1] & x_i[2]);

endmodule
`default_nettype wire

// File: rtl/nina_decoder_d1_k1.sv
`default_nettype none
// ============================================================================
// nina_decoder_d1_k1 : 2-stage majority-correcting share decoder with fault
//                      counter and sticky alarm
// Rev 1.0            : initial release
// ============================================================================
module nina_decoder_d1_k1
    import nina_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  share_t           port_a_0,
    input  share_t           port_a_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             port_z,
    output logic             out_fault,
    output logic [CNT_W-1:0] fault_cnt,
    output logic             alarm,
    input  logic             clear_alarm
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q;
    logic               a_valid_q;
    share_t             a_sh_q [NINA_SHARES];
    logic               b_valid_q;
    logic               z_q;
    logic               fault_q;
    logic [CNT_W-1:0]   fault_cnt_q;
    logic [CNT_W-1:0]   fault_cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               alarm_q;

    logic [NINA_SHARES-1:0] maj;
    logic [NINA_SHARES-1:0] sh_bad;
    logic                   vote_z;
    logic                   vote_fault;
    logic                   b_ready;
    logic                   a_ready;
    logic                   in_xfer;
    logic                   ab_xfer;
    logic                   trip;

    // Each share is corrected on its own; shares only meet after the vote.
    for (genvar s = 0; s < NINA_SHARES; s++) begin : g_share
        nina_maj3 u_maj (
            .x_i (a_sh_q[s]),
            .y_o (maj[s])
        );
        assign sh_bad[s] = !is_consistent(a_sh_q[s]);
    end

    assign vote_z     = ^maj;
    assign vote_fault = |sh_bad;

    assign b_ready  = !b_valid_q | out_ready;
    assign a_ready  = !a_valid_q | b_ready;
    assign in_ready = a_ready & (state_q == RUN);
    assign in_xfer  = in_valid & in_ready;
    assign ab_xfer  = a_valid_q & b_ready;

    assign cnt_inc     = (fault_cnt_q == CNT_MAX) ? fault_cnt_q : fault_cnt_q + CNT_W'(1);
    assign fault_cnt_d = (ab_xfer & vote_fault) ? cnt_inc : fault_cnt_q;
    assign trip        = (state_q == RUN) & ab_xfer & vote_fault & (cnt_inc >= THRESH_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            a_valid_q   <= 1'b0;
            a_sh_q[0]   <= '0;
            a_sh_q[1]   <= '0;
            b_valid_q   <= 1'b0;
            z_q         <= 1'b0;
            fault_q     <= 1'b0;
            fault_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    fault_cnt_q <= fault_cnt_d;
                    if (trip) begin
                        // Triggering beat and anything behind it are discarded.
                        state_q   <= ALARM;
                        alarm_q   <= 1'b1;
                        a_valid_q <= 1'b0;
                        b_valid_q <= 1'b0;
                        z_q       <= 1'b0;
                        fault_q   <= 1'b0;
                    end else begin
                        if (in_xfer) begin
                            a_valid_q <= 1'b1;
                            a_sh_q[0] <= port_a_0;
                            a_sh_q[1] <= port_a_1;
                        end else if (ab_xfer) begin
                            a_valid_q <= 1'b0;
                        end
                        if (ab_xfer) begin
                            b_valid_q <= 1'b1;
                            z_q       <= vote_z;
                            fault_q   <= vote_fault;
                        end else if (out_ready) begin
                            b_valid_q <= 1'b0;
                        end
                    end
                end
                ALARM: begin
                    if (clear_alarm) begin
                        state_q     <= RUN;
                        alarm_q     <= 1'b0;
                        fault_cnt_q <= '0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign out_valid = b_valid_q;
    assign port_z    = z_q;
    assign out_fault = fault_q;
    assign fault_cnt = fault_cnt_q;
    assign alarm     = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_nina_decoder_d1_k1.sv
`default_nettype none
// ============================================================================
// tb_nina_decoder_d1_k1 : two decoder configurations driven in lockstep and
//                         compared against a transaction-level reference
// Rev 1.0               : initial release
// ============================================================================
module tb_nina_decoder_d1_k1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] a0 = 3'b000;
    logic [2:0] a1 = 3'b000;
    logic       out_ready = 1'b0;
    logic       clear_alarm = 1'b0;

    logic       ir [2];
    logic       ov [2];
    logic       pz [2];
    logic       of [2];
    logic       al [2];
    logic [7:0] fc0;
    logic [1:0] fc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nina_decoder_d1_k1 #(.CNT_W(8), .ALARM_THRESH(4)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .port_a_0(a0), .port_a_1(a1), .out_valid(ov[0]), .out_ready(out_ready),
        .port_z(pz[0]), .out_fault(of[0]), .fault_cnt(fc0), .alarm(al[0]),
        .clear_alarm(clear_alarm)
    );

    nina_decoder_d1_k1 #(.CNT_W(2), .ALARM_THRESH(3)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .port_a_0(a0), .port_a_1(a1), .out_valid(ov[1]), .out_ready(out_ready),
        .port_z(pz[1]), .out_fault(of[1]), .fault_cnt(fc1), .alarm(al[1]),
        .clear_alarm(clear_alarm)
    );

    // Reference: in-flight beats oldest first; in_b marks the one in the output stage.
    typedef struct packed {
        logic z;
        logic f;
        logic in_b;
    } beat_t;

    beat_t mq [2][$];
    int    mcnt   [2];
    bit    malarm [2];
    int    cmax   [2] = '{255, 3};
    int    thr    [2] = '{4, 3};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic beat_t vote(input logic [2:0] s0, input logic [2:0] s1);
        beat_t b;
        logic m0, m1;
        m0 = ($countones(s0) >= 2);
        m1 = ($countones(s1) >= 2);
        b.z    = m0 ^ m1;
        b.f    = !(s0 == 3'd0 || s0 == 3'd7) || !(s1 == 3'd0 || s1 == 3'd7);
        b.in_b = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mcnt[i]   = 0;
            malarm[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        bit    b_occ, a_occ, b_rdy, acc;
        int    n;
        beat_t nb;
        n     = mq[i].size();
        b_occ = (n > 0) && mq[i][0].in_b;
        a_occ = (n > 0) && !mq[i][n-1].in_b;
        if (malarm[i]) begin
            if (clear_alarm) begin
                malarm[i] = 1'b0;
                mcnt[i]   = 0;
            end
            return;
        end
        b_rdy = !b_occ || out_ready;
        acc   = in_valid && (!a_occ || b_rdy);
        if (b_occ && out_ready) void'(mq[i].pop_front());
        if (a_occ && b_rdy) begin
            nb = mq[i][0];
            if (nb.f) begin
                if (mcnt[i] < cmax[i]) mcnt[i]++;
                if (mcnt[i] >= thr[i]) begin
                    malarm[i] = 1'b1;
                    mq[i].delete();
                    return;
                end
            end
            nb.in_b  = 1'b1;
            mq[i][0] = nb;
        end
        if (acc) mq[i].push_back(vote(a0, a1));
    endtask

    task automatic check_dut(input int i);
        bit          b_occ, a_occ, eov, eir;
        int          n;
        logic [31:0] fc;
        n     = mq[i].size();
        b_occ = (n > 0) && mq[i][0].in_b;
        a_occ = (n > 0) && !mq[i][n-1].in_b;
        eov   = !malarm[i] && b_occ;
        eir   = !malarm[i] && (!a_occ || !b_occ || out_ready);
        fc    = (i == 0) ? {24'd0, fc0} : {30'd0, fc1};
        check_eq($sformatf("u%0d.out_valid", i), {31'd0, ov[i]}, {31'd0, eov});
        check_eq($sformatf("u%0d.in_ready", i), {31'd0, ir[i]}, {31'd0, eir});
        check_eq($sformatf("u%0d.alarm", i), {31'd0, al[i]}, {31'd0, malarm[i]});
        check_eq($sformatf("u%0d.fault_cnt", i), fc, mcnt[i]);
        if (eov) begin
            check_eq($sformatf("u%0d.port_z", i), {31'd0, pz[i]}, {31'd0, mq[i][0].z});
            check_eq($sformatf("u%0d.out_fault", i), {31'd0, of[i]}, {31'd0, mq[i][0].f});
        end else if (malarm[i]) begin
            check_eq($sformatf("u%0d.port_z_alarm", i), {31'd0, pz[i]}, 32'd0);
            check_eq($sformatf("u%0d.out_fault_alarm", i), {31'd0, of[i]}, 32'd0);
        end
    endtask

    // One clock: drive at negedge, step model on posedge, check at next negedge.
    task automatic cyc(input logic iv, input logic [2:0] s0, input logic [2:0] s1,
                       input logic ordy, input logic clr, output logic acc0);
        in_valid    = iv;
        a0          = s0;
        a1          = s1;
        out_ready   = ordy;
        clear_alarm = clr;
        #1;
        acc0 = iv & ir[0];
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic idle(input int n, input logic ordy, input logic clr);
        logic unused;
        for (int k = 0; k < n; k++) cyc(1'b0, 3'b000, 3'b000, ordy, clr, unused);
    endtask

    task automatic reset_outputs_check(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s.u%0d.out_valid", tag, i), {31'd0, ov[i]}, 32'd0);
            check_eq($sformatf("%s.u%0d.port_z", tag, i), {31'd0, pz[i]}, 32'd0);
            check_eq($sformatf("%s.u%0d.out_fault", tag, i), {31'd0, of[i]}, 32'd0);
            check_eq($sformatf("%s.u%0d.alarm", tag, i), {31'd0, al[i]}, 32'd0);
        end
        check_eq({tag, ".u0.fault_cnt"}, {24'd0, fc0}, 32'd0);
        check_eq({tag, ".u1.fault_cnt"}, {30'd0, fc1}, 32'd0);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   budget;
        logic [2:0] r0, r1;

        model_reset();
        repeat (3) @(negedge clk);
        reset_outputs_check("por");
        reset = 1'b1;

        // Clean beat then corrected beat.
        cyc(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, acc);
        cyc(1'b1, 3'b101, 3'b010, 1'b1, 1'b0, acc);
        idle(3, 1'b1, 1'b0);
        check_eq("cnt_after_one_fault", {24'd0, fc0}, 32'd1);

        // Eight clean alternating beats with a 3-cycle stall in the middle.
        sent   = 0;
        budget = 0;
        while (sent < 8 && budget < 100) begin
            cyc(1'b1, sent[0] ? 3'b111 : 3'b000, 3'b000,
                !(budget >= 3 && budget < 6), 1'b0, acc);
            if (acc) sent++;
            budget++;
        end
        check_eq("stream_sent_within_budget", sent, 8);
        idle(4, 1'b1, 1'b0);

        // Fill both stages, then reset asynchronously between edges.
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, acc);
        cyc(1'b1, 3'b000, 3'b111, 1'b0, 1'b0, acc);
        cyc(1'b1, 3'b111, 3'b111, 1'b0, 1'b0, acc);
        check_eq("both_stages_full", {31'd0, ov[0]}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        reset_outputs_check("async_rst");
        @(negedge clk);
        reset = 1'b1;
        idle(3, 1'b1, 1'b0);

        // Four back-to-back faulty beats: third trips the small config, fourth the default.
        for (int k = 0; k < 4; k++) cyc(1'b1, 3'b110, 3'b000, 1'b1, 1'b0, acc);
        idle(2, 1'b1, 1'b0);
        check_eq("alarm_after_4", {31'd0, al[0]}, 32'd1);
        check_eq("cnt_at_alarm", {24'd0, fc0}, 32'd4);
        check_eq("in_ready_in_alarm", {31'd0, ir[0]}, 32'd0);
        idle(1, 1'b1, 1'b1);
        check_eq("alarm_cleared", {31'd0, al[0]}, 32'd0);
        check_eq("in_ready_after_clear", {31'd0, ir[0]}, 32'd1);

        // Small-counter config: alarm every third faulty beat, no wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) cyc(1'b1, 3'b000, 3'b001, 1'b1, 1'b0, acc);
            idle(2, 1'b1, 1'b0);
            check_eq($sformatf("small_alarm_r%0d", r), {31'd0, al[1]}, 32'd1);
            check_eq($sformatf("small_cnt_r%0d", r), {30'd0, fc1}, 32'd3);
            idle(1, 1'b1, 1'b1);
        end

        // Randomized traffic with stalls, faults and stray clears.
        for (int k = 0; k < 3000; k++) begin
            r0 = ($urandom_range(0, 1) == 0) ? {3{1'($urandom_range(0, 1))}} : 3'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 2) != 0) ? {3{1'($urandom_range(0, 1))}} : 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 3) != 0), r0, r1, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0), acc);
        end
        idle(4, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
